// File: rtl/snes_pad_responder.sv
// Controller-side NES/SNES pad model: synchronizes the reader's latch and clock,
// snapshots the button word on an accepted latch and shifts it out active-low.
module snes_pad_responder #(
  parameter int SYNC_STAGES      = 2,
  parameter int LATCH_MIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snes_mode,
  input  logic [11:0] buttons,
  input  logic        pad_latch,
  input  logic        pad_clk,
  output logic        pad_data,
  output logic        busy,
  output logic [4:0]  bit_index,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  localparam int CW = $clog2(LATCH_MIN_CYCLES + 1) + 1;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic                   latch_hist_q, latch_hist_d;
  logic                   clk_hist_q, clk_hist_d;
  logic [CW-1:0]          count_q, count_d;
  logic [15:0]            shreg_q, shreg_d;
  logic                   mode_q, mode_d;
  logic [4:0]             bit_index_q, bit_index_d;
  logic                   pad_data_q, pad_data_d;
  logic                   frame_done_q, frame_done_d;

  logic        latch_s, clk_s;
  logic        latch_rise, latch_fall, clk_rise;
  logic [15:0] live_word;
  logic [15:0] shifted;
  logic [4:0]  next_index;
  logic [4:0]  frame_len;

  // Pressed-high frame word; NES order is A,B,select,start,up,down,left,right.
  function automatic logic [15:0] frame_word(input logic [11:0] b, input logic m);
    if (m) frame_word = {4'b0000, b};
    else   frame_word = {8'h00, b[7:2], b[0], b[8]};
  endfunction

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_hist_q;
  assign latch_fall = ~latch_s & latch_hist_q;
  assign clk_rise   = clk_s & ~clk_hist_q;
  assign live_word  = frame_word(buttons, snes_mode);
  assign shifted    = {1'b0, shreg_q[15:1]};
  assign next_index = bit_index_q + 5'd1;
  assign frame_len  = mode_q ? 5'd16 : 5'd8;

  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pad_latch};
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], pad_clk};
    latch_hist_d = latch_s;
    clk_hist_d   = clk_s;
    state_d      = state_q;
    count_d      = count_q;
    shreg_d      = shreg_q;
    mode_d       = mode_q;
    bit_index_d  = bit_index_q;
    pad_data_d   = pad_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        pad_data_d = 1'b1;
      end
      S_LOAD: begin
        if (latch_fall) begin
          if (count_q >= CW'(LATCH_MIN_CYCLES)) begin
            state_d     = S_SHIFT;
            bit_index_d = 5'd0;
            pad_data_d  = ~shreg_q[0];
          end else begin
            state_d    = S_IDLE;
            pad_data_d = 1'b1;
          end
        end else begin
          if (count_q < CW'(LATCH_MIN_CYCLES)) count_d = count_q + CW'(1);
          shreg_d    = live_word;
          mode_d     = snes_mode;
          pad_data_d = ~live_word[0];
        end
      end
      S_SHIFT: begin
        if (clk_rise && !latch_rise) begin
          shreg_d     = shifted;
          bit_index_d = next_index;
          if (next_index == frame_len) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
            pad_data_d   = 1'b0;
          end else begin
            pad_data_d = ~shifted[0];
          end
        end
      end
      S_DONE: begin
        pad_data_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // A latch rise restarts the frame from any state except LOAD; it beats a clock edge.
    if (latch_rise && state_q != S_LOAD) begin
      state_d      = S_LOAD;
      count_d      = CW'(1);
      bit_index_d  = 5'd0;
      shreg_d      = live_word;
      mode_d       = snes_mode;
      pad_data_d   = ~live_word[0];
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '0;
      latch_hist_q <= 1'b0;
      clk_hist_q   <= 1'b0;
      state_q      <= S_IDLE;
      count_q      <= '0;
      shreg_q      <= '0;
      mode_q       <= 1'b0;
      bit_index_q  <= 5'd0;
      pad_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      latch_sync_q <= latch_sync_d;
      clk_sync_q   <= clk_sync_d;
      latch_hist_q <= latch_hist_d;
      clk_hist_q   <= clk_hist_d;
      state_q      <= state_d;
      count_q      <= count_d;
      shreg_q      <= shreg_d;
      mode_q       <= mode_d;
      bit_index_q  <= bit_index_d;
      pad_data_q   <= pad_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pad_data   = pad_data_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign bit_index  = bit_index_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule
